// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Brief    : Shared encodings for the snake draw path: cell status codes,
//             colour constants, default screen geometry and plotter states.
//  Revision : 1.0  initial release
// ============================================================================
package snake_pkg;

    // Cell kinds as delivered by the game controller
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BODY  = 2'b01;
    localparam logic [1:0] ST_FOOD  = 2'b10;
    localparam logic [1:0] ST_HEAD  = 2'b11;

    // 3-bit RGB colours
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    // Default visible screen geometry
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Plotter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } plot_state_t;

    // Map a cell kind to its pixel colour; empty cells use the background
    function automatic logic [2:0] status_colour(input logic [1:0] st,
                                                 input logic [2:0] bg);
        logic [2:0] col;
        case (st)
            ST_BODY: col = COL_GREEN;
            ST_FOOD: col = COL_RED;
            ST_HEAD: col = COL_YELLOW;
            default: col = bg;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xy_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module   : xy_scan_counter
//  Brief    : 2-D raster counter. x runs fast from 0 to i_x_max, y steps when
//             x wraps. Exposes the value the counter takes at the next edge so
//             a registered consumer can stay aligned with it, plus a flag for
//             the final raster position.
//  Revision : 1.0  initial release
// ============================================================================
module xy_scan_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [XW-1:0] i_x_max,
    input  logic [YW-1:0] i_y_max,
    output logic [XW-1:0] o_x_next,
    output logic [YW-1:0] o_y_next,
    output logic          o_last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next raster position: clear wins, otherwise advance when enabled
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (i_en) begin
            if (x_q == i_x_max) begin
                x_d = '0;
                if (y_q == i_y_max) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign o_x_next = x_d;
    assign o_y_next = y_d;
    assign o_last   = (x_q == i_x_max) && (y_q == i_y_max);

endmodule
`default_nettype wire

// File: rtl/snake_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : snake_plotter
//  Brief    : Expands a cell-draw request into a BLOCK x BLOCK square of pixel
//             writes, or sweeps the whole screen with the background colour.
//             Pixels that fall off the right/bottom edge are suppressed while
//             the block still takes its full duration.
//  Revision : 1.0  initial release
// ============================================================================
module snake_plotter
    import snake_pkg::*;
#(
    parameter int         BLOCK     = 4,
    parameter int         SCREEN_W  = SCREEN_W_DEF,
    parameter int         SCREEN_H  = SCREEN_H_DEF,
    parameter logic [2:0] BG_COLOUR = COL_BLACK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [1:0] status,
    input  logic       go,
    input  logic       clear,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] C_BLK_X_MAX = 8'(BLOCK - 1);
    localparam logic [6:0] C_BLK_Y_MAX = 7'(BLOCK - 1);
    localparam logic [7:0] C_SCR_X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] C_SCR_Y_MAX = 7'(SCREEN_H - 1);
    localparam logic [8:0] C_LIM_X     = 9'(SCREEN_W);
    localparam logic [7:0] C_LIM_Y     = 8'(SCREEN_H);

    plot_state_t state_q, state_d;
    logic [7:0]  lat_x_q, lat_x_d;
    logic [6:0]  lat_y_q, lat_y_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_plot_q, vga_plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic [7:0]  w_x_max;
    logic [6:0]  w_y_max;
    logic [7:0]  w_dx_next;
    logic [6:0]  w_dy_next;
    logic        w_cnt_last;
    logic [7:0]  w_base_x;
    logic [6:0]  w_base_y;
    logic [8:0]  w_sum_x;
    logic [7:0]  w_sum_y;
    logic        w_in_view;

    // Counter is held at the origin while idle so the accept edge emits
    // offset (0,0); it advances on every pixel of a draw or clear.
    assign w_cnt_clr = (state_q == IDLE);
    assign w_cnt_en  = (state_q == DRAW) || (state_q == CLEAR);
    assign w_x_max   = (state_q == CLEAR) ? C_SCR_X_MAX : C_BLK_X_MAX;
    assign w_y_max   = (state_q == CLEAR) ? C_SCR_Y_MAX : C_BLK_Y_MAX;

    xy_scan_counter #(
        .XW (8),
        .YW (7)
    ) u_scan (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_x_max  (w_x_max),
        .i_y_max  (w_y_max),
        .o_x_next (w_dx_next),
        .o_y_next (w_dy_next),
        .o_last   (w_cnt_last)
    );

    // Origin of the pixel being registered next: live inputs on the accept
    // edge, latched corner during a draw, screen origin for a clear
    always_comb begin
        w_base_x = '0;
        w_base_y = '0;
        if (state_q == DRAW) begin
            w_base_x = lat_x_q;
            w_base_y = lat_y_q;
        end else if ((state_q == IDLE) && !clear) begin
            w_base_x = x_in;
            w_base_y = y_in;
        end
    end

    // Widened sums so off-screen pixels are detected instead of wrapping
    assign w_sum_x   = {1'b0, w_base_x} + {1'b0, w_dx_next};
    assign w_sum_y   = {1'b0, w_base_y} + {1'b0, w_dy_next};
    assign w_in_view = (w_sum_x < C_LIM_X) && (w_sum_y < C_LIM_Y);

    // Sequencing and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (clear) begin
                    state_d      = CLEAR;
                    busy_d       = 1'b1;
                    vga_x_d      = w_sum_x[7:0];
                    vga_y_d      = w_sum_y[6:0];
                    vga_colour_d = BG_COLOUR;
                    vga_plot_d   = 1'b1;
                end else if (go) begin
                    state_d      = DRAW;
                    busy_d       = 1'b1;
                    lat_x_d      = x_in;
                    lat_y_d      = y_in;
                    vga_x_d      = w_sum_x[7:0];
                    vga_y_d      = w_sum_y[6:0];
                    vga_colour_d = status_colour(status, BG_COLOUR);
                    vga_plot_d   = w_in_view;
                end
            end
            DRAW, CLEAR: begin
                if (w_cnt_last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    vga_x_d    = w_sum_x[7:0];
                    vga_y_d    = w_sum_y[6:0];
                    vga_plot_d = w_in_view;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_x_q      <= lat_x_d;
            lat_y_q      <= lat_y_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: doc/snake_plotter.md
Name: snake_plotter

Overview:
- Consumer end of the game controller's draw interface. Accepts one cell-draw request (x, y, go, status) and expands it into a BLOCK x BLOCK square of single-pixel writes toward vga_adapter.
- Also performs a full-screen clear sweep.
- Sits between the game control FSM and vga_adapter. Reports busy and done so the controller can sequence requests.

Parameters:
- BLOCK, 4: side length of one snake cell in pixels; power of two, 1..8.
- SCREEN_W, 160: visible pixel columns.
- SCREEN_H, 120: visible pixel rows.
- BG_COLOUR, 3'b000: colour for status 00 and for clear.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_in  in  8  top-left pixel column of the cell.
- y_in  in  7  top-left pixel row of the cell.
- status  in  2  cell kind: 00 empty, 01 body, 10 food, 11 head.
- go  in  1  request strobe, sampled only while busy=0.
- clear  in  1  full-screen clear request, sampled only while busy=0.
- vga_x  out  8  pixel column to adapter.
- vga_y  out  7  pixel row to adapter.
- vga_colour  out  3  pixel colour to adapter.
- vga_plot  out  1  write-enable to adapter, one pixel per cycle.
- busy  out  1  high while a request is being serviced.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0; offset counters 0. Reset mid-operation aborts with no further plots.
- Colour map: 00 -> BG_COLOUR, 01 -> 3'b010 (green), 10 -> 3'b100 (red), 11 -> 3'b110 (yellow).
- IDLE:
  - clear=1 at a clock edge -> CLEAR. clear wins over a simultaneous go.
  - else go=1 -> DRAW. Latch x_in, y_in and colour.
  - busy rises on the same edge.
- DRAW: offset counters dx (column, fast) and dy (row) each run 0..BLOCK-1.
  - One pixel per cycle: vga_x = x_lat+dx, vga_y = y_lat+dy, vga_plot=1. Outputs are registered.
  - First pixel is valid the cycle after go is accepted.
  - Exactly BLOCK*BLOCK cycles, raster order, row 0 first.
- Clipping: sums are computed at 9/8-bit width. A pixel with x >= SCREEN_W or y >= SCREEN_H gets vga_plot=0, but the counters still advance, so DRAW duration is constant. No wrap-around onto the opposite edge.
- CLEAR: sweeps x 0..SCREEN_W-1 (fast) and y 0..SCREEN_H-1 with BG_COLOUR, vga_plot=1, one pixel per cycle (19200 cycles at defaults).
- DONE: the cycle after the last pixel.
  - vga_plot=0, done=1 for exactly one cycle, busy=0 in that same cycle.
  - Then IDLE.
  - A go present during DONE is not accepted; it is first sampled the following cycle.
- go and clear while busy=1 are ignored (not queued). go is level-sampled: held high, it re-triggers after each DONE.
- Inputs x_in, y_in, status may change freely after acceptance.

Decomposition:
- Shared package snake_pkg:
  - status encodings (ST_EMPTY, ST_BODY, ST_FOOD, ST_HEAD)
  - colour constants
  - SCREEN_W/SCREEN_H defaults
  - plotter state enum (IDLE, DRAW, CLEAR, DONE)
- One natural sub-module, xy_scan_counter: a parameterised 2-D raster counter (width/height limits, enable, last flag). Instanced once for BLOCK and once for screen, or a single instance with muxed limits.

Test Plan:
- Reset, then go with x_in=10, y_in=20, status=01 -> next 16 cycles plot (10..13, 20..23) in raster order, colour 010. Then done=1 for one cycle with busy=0, vga_plot=0 afterward.
- go with x_in=158, y_in=118, status=10 -> 16 DRAW cycles. vga_plot=1 only for x in {158,159} and y in {118,119} (4 pixels), colour 100. done arrives at cycle 17.
- go and clear asserted together from IDLE -> CLEAR runs 19200 plot cycles covering (0,0)..(159,119) with colour 000. No cell draw occurs.
- go pulsed mid-DRAW and again in the DONE cycle -> both ignored. Exactly 16 plots. busy=0 after done.
- Reset asserted asynchronously at pixel 7 of a DRAW -> vga_plot, busy and done go 0 immediately. A fresh go after release draws a full 16-pixel block from offset (0,0).
- go held high continuously with status=11 -> back-to-back blocks: 16 plots, 1 DONE cycle, 1 IDLE cycle, repeating. Colour 110.
